// File: rtl/spi_device.sv
// SPI mode-0 slave front end: oversamples SCK/CS/MOSI in the clk domain,
// deserialises MOSI into byte strobes and serialises control's bytes onto MISO.
module spi_device #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic       spi_cs,
  output logic [7:0] spi_rx_data,
  output logic       spi_rx_strobe,
  input  logic [7:0] spi_tx_data,
  input  logic       spi_tx_strobe,
  output logic       spi_tx_underrun
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_d;
  logic                   cs_d;
  logic [2:0]             bit_cnt;
  logic [7:0]             rx_shift;
  logic [7:0]             tx_shift;
  logic [7:0]             holding;
  logic                   holding_valid;
  logic                   rx_done;

  logic sck_s, cs_s, mosi_s;
  logic sck_rise, sck_fall, cs_rise, cs_fall;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_rise  = cs_s & ~cs_d;
  assign cs_fall  = ~cs_s & cs_d;

  assign spi_cs      = cs_s;
  assign spi_miso_oe = ~cs_s;

  // Pin synchronisers plus one extra registered copy for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
    end
  end

  // Strobes carry no back-pressure: spi_rx_strobe qualifies spi_rx_data for
  // exactly one cycle, spi_tx_strobe loads spi_tx_data in the cycle it is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      bit_cnt         <= 3'd0;
      rx_shift        <= 8'h00;
      tx_shift        <= 8'h00;
      holding         <= 8'h00;
      holding_valid   <= 1'b0;
      rx_done         <= 1'b0;
      spi_miso        <= 1'b0;
      spi_rx_data     <= 8'h00;
      spi_rx_strobe   <= 1'b0;
      spi_tx_underrun <= 1'b0;
    end else begin
      rx_done         <= 1'b0;
      spi_rx_strobe   <= rx_done;
      spi_tx_underrun <= 1'b0;
      if (rx_done) begin
        spi_rx_data <= rx_shift;
      end
      if (spi_tx_strobe) begin
        holding       <= spi_tx_data;
        holding_valid <= 1'b1;
      end

      case (state)
        IDLE: begin
          // Any byte staged while deselected is dropped; byte 0 always returns 0x00.
          if (cs_fall) begin
            state         <= ACTIVE;
            bit_cnt       <= 3'd0;
            rx_shift      <= 8'h00;
            tx_shift      <= 8'h00;
            spi_miso      <= 1'b0;
            holding_valid <= 1'b0;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state         <= IDLE;
            bit_cnt       <= 3'd0;
            holding_valid <= 1'b0;
            spi_miso      <= 1'b0;
          end else if (sck_rise) begin
            rx_shift <= {rx_shift[6:0], mosi_s};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_done <= 1'b1;
            end
          end else if (sck_fall) begin
            if (bit_cnt != 3'd0) begin
              tx_shift <= {tx_shift[6:0], 1'b0};
              spi_miso <= tx_shift[6];
            end else if (spi_tx_strobe) begin
              tx_shift      <= spi_tx_data;
              spi_miso      <= spi_tx_data[7];
              holding_valid <= 1'b0;
            end else if (holding_valid) begin
              tx_shift      <= holding;
              spi_miso      <= holding[7];
              holding_valid <= 1'b0;
            end else begin
              tx_shift        <= 8'h00;
              spi_miso        <= 1'b0;
              spi_tx_underrun <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_device.sv
// Bench for spi_device: table of SPI transactions plus randomized ones, each
// checked against a byte-level model of what MOSI/MISO/underrun should show.
module tb_spi_device;

  localparam int SYNC_STAGES = 2;

  // mode per byte: 0 none, 1 strobe mid-byte, 2 strobe 1 clk after rx_strobe,
  // 3 two back-to-back strobes (second value must win)
  typedef struct packed {
    logic [2:0]      n;
    logic [3:0][7:0] mosi;
    logic [3:0][1:0] mode;
    logic [3:0][7:0] val;
    logic [3:0][7:0] exp_miso;
    logic [2:0]      exp_under;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       spi_sck;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic       spi_cs;
  logic [7:0] spi_rx_data;
  logic       spi_rx_strobe;
  logic [7:0] spi_tx_data;
  logic       spi_tx_strobe;
  logic       spi_tx_underrun;

  int n_tests = 0;
  int n_fail  = 0;
  int cycle   = 0;
  int under_cnt = 0;
  logic [7:0] got_q[$];
  int         got_cyc_q[$];
  logic [7:0] exp_q[$];
  vec_t       vecs[7];

  spi_device #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .spi_sck        (spi_sck),
    .spi_cs_n       (spi_cs_n),
    .spi_mosi       (spi_mosi),
    .spi_miso       (spi_miso),
    .spi_miso_oe    (spi_miso_oe),
    .spi_cs         (spi_cs),
    .spi_rx_data    (spi_rx_data),
    .spi_rx_strobe  (spi_rx_strobe),
    .spi_tx_data    (spi_tx_data),
    .spi_tx_strobe  (spi_tx_strobe),
    .spi_tx_underrun(spi_tx_underrun)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // monitor: record received bytes with their arrival cycle, count underruns
  always @(negedge clk) begin
    if (spi_rx_strobe) begin
      got_q.push_back(spi_rx_data);
      got_cyc_q.push_back(cycle);
    end
    if (spi_tx_underrun) under_cnt = under_cnt + 1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic watch_rx(input logic [7:0] val);
    fork
      begin
        for (int t = 0; t < 12; t++) begin
          @(negedge clk);
          if (spi_rx_strobe) begin
            spi_tx_data   = val;
            spi_tx_strobe = 1'b1;
            @(negedge clk);
            spi_tx_strobe = 1'b0;
            break;
          end
        end
      end
    join_none
  endtask

  // clk/8 SCK: 4 clk low (MOSI set, MISO sampled at end), 4 clk high
  task automatic partial_bits(input logic [7:0] pat, input int nbits);
    for (int k = 0; k < nbits; k++) begin
      spi_mosi = pat[7-k];
      repeat (4) @(negedge clk);
      spi_sck = 1'b1;
      repeat (4) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic run_xfer(input string name, input vec_t v);
    int base;
    int u0;
    int cyc_q[$];
    logic [3:0][7:0] miso_got;
    logic [7:0] e;
    base = got_q.size();
    u0 = under_cnt;
    miso_got = '0;
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int j = 0; j < int'(v.n); j++) begin
      for (int b = 7; b >= 0; b--) begin
        spi_mosi = v.mosi[j][b];
        if (b == 5 && v.mode[j] == 2'd1) begin
          spi_tx_data = v.val[j]; spi_tx_strobe = 1'b1;
          @(negedge clk);
          spi_tx_strobe = 1'b0;
          repeat (3) @(negedge clk);
        end else if (b == 5 && v.mode[j] == 2'd3) begin
          spi_tx_data = ~v.val[j]; spi_tx_strobe = 1'b1;
          @(negedge clk);
          spi_tx_data = v.val[j];
          @(negedge clk);
          spi_tx_strobe = 1'b0;
          repeat (2) @(negedge clk);
        end else begin
          repeat (4) @(negedge clk);
        end
        miso_got[j][b] = spi_miso;
        spi_sck = 1'b1;
        if (b == 0) begin
          cyc_q.push_back(cycle + SYNC_STAGES + 2);
          exp_q.push_back(v.mosi[j]);
          if (v.mode[j] == 2'd2) watch_rx(v.val[j]);
        end
        repeat (4) @(negedge clk);
        spi_sck = 1'b0;
        // last fall coincides with CS rise: that SCK edge must be dropped
        if (b == 0 && j == int'(v.n) - 1) spi_cs_n = 1'b1;
      end
    end
    repeat (10) @(negedge clk);
    check({name, " cs_idle"}, 32'(spi_cs), 32'd1);
    check({name, " oe_idle"}, 32'(spi_miso_oe), 32'd0);
    check({name, " n_strobes"}, 32'(got_q.size() - base), 32'(v.n));
    for (int j = 0; j < int'(v.n); j++) begin
      e = exp_q.pop_front();
      if (base + j < got_q.size()) begin
        check({name, " rx_data"}, 32'(got_q[base+j]), 32'(e));
        check({name, " rx_latency"}, 32'(got_cyc_q[base+j]), 32'(cyc_q[j]));
      end
      check({name, " miso_byte"}, 32'(miso_got[j]), 32'(v.exp_miso[j]));
    end
    check({name, " underruns"}, 32'(under_cnt - u0), 32'(v.exp_under));
  endtask

  // model: MISO byte i is the last value handed over during byte i-1,
  // otherwise 0x00 with one underrun; byte 0 is always 0x00
  function automatic vec_t model(input vec_t v);
    vec_t r;
    r = v;
    r.exp_miso  = '0;
    r.exp_under = '0;
    for (int i = 1; i < int'(v.n); i++) begin
      if (v.mode[i-1] != 2'd0) r.exp_miso[i] = v.val[i-1];
      else r.exp_under = r.exp_under + 3'd1;
    end
    return r;
  endfunction

  initial begin
    int base;
    int u0;
    vec_t rv;

    vecs[0] = '{n:3'd1, mosi:{8'h00,8'h00,8'h00,8'hA5}, mode:{2'd0,2'd0,2'd0,2'd0},
                val:{8'h00,8'h00,8'h00,8'h00}, exp_miso:{8'h00,8'h00,8'h00,8'h00}, exp_under:3'd0};
    vecs[1] = '{n:3'd2, mosi:{8'h00,8'h00,8'h00,8'h12}, mode:{2'd0,2'd0,2'd0,2'd2},
                val:{8'h00,8'h00,8'h00,8'h3C}, exp_miso:{8'h00,8'h00,8'h3C,8'h00}, exp_under:3'd0};
    vecs[2] = '{n:3'd2, mosi:{8'h00,8'h00,8'h56,8'h34}, mode:{2'd0,2'd0,2'd0,2'd0},
                val:{8'h00,8'h00,8'h00,8'h00}, exp_miso:{8'h00,8'h00,8'h00,8'h00}, exp_under:3'd1};
    vecs[3] = '{n:3'd3, mosi:{8'h00,8'h01,8'h7E,8'hC3}, mode:{2'd0,2'd0,2'd1,2'd1},
                val:{8'h00,8'h00,8'h81,8'h5A}, exp_miso:{8'h00,8'h81,8'h5A,8'h00}, exp_under:3'd0};
    vecs[4] = '{n:3'd3, mosi:{8'h00,8'h99,8'h0F,8'hF0}, mode:{2'd0,2'd0,2'd0,2'd1},
                val:{8'h00,8'h00,8'h00,8'hFF}, exp_miso:{8'h00,8'h00,8'hFF,8'h00}, exp_under:3'd1};
    vecs[5] = '{n:3'd2, mosi:{8'h00,8'h00,8'hAA,8'h55}, mode:{2'd0,2'd0,2'd0,2'd3},
                val:{8'h00,8'h00,8'h00,8'h96}, exp_miso:{8'h00,8'h00,8'h96,8'h00}, exp_under:3'd0};
    vecs[6] = '{n:3'd4, mosi:{8'h7F,8'hFE,8'h80,8'h01}, mode:{2'd1,2'd1,2'd0,2'd2},
                val:{8'h11,8'hE7,8'h00,8'h6C}, exp_miso:{8'hE7,8'h00,8'h6C,8'h00}, exp_under:3'd1};

    // reset
    reset_n = 1'b0; spi_sck = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    spi_tx_data = 8'h00; spi_tx_strobe = 1'b0;
    repeat (5) @(negedge clk);
    check("reset spi_cs", 32'(spi_cs), 32'd1);
    check("reset miso_oe", 32'(spi_miso_oe), 32'd0);
    check("reset miso", 32'(spi_miso), 32'd0);
    check("reset rx_data", 32'(spi_rx_data), 32'd0);
    check("reset underrun", 32'(spi_tx_underrun), 32'd0);
    reset_n = 1'b1;

    // idle pins: nothing happens for 100 clk
    base = got_q.size(); u0 = under_cnt;
    repeat (100) @(negedge clk);
    check("idle strobes", 32'(got_q.size() - base), 32'd0);
    check("idle underruns", 32'(under_cnt - u0), 32'd0);
    check("idle spi_cs", 32'(spi_cs), 32'd1);
    check("idle miso_oe", 32'(spi_miso_oe), 32'd0);

    // table-driven transactions
    for (int i = 0; i < 7; i++) begin
      run_xfer($sformatf("vec%0d", i), vecs[i]);
      repeat (6) @(negedge clk);
    end

    // CS deasserted after 5 bits: partial byte discarded
    base = got_q.size(); u0 = under_cnt;
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    partial_bits(8'hB3, 4);
    spi_mosi = 1'b1;
    repeat (4) @(negedge clk);
    check("abort miso_oe", 32'(spi_miso_oe), 32'd1);
    spi_sck = 1'b1;
    repeat (4) @(negedge clk);
    spi_sck = 1'b0; spi_cs_n = 1'b1;
    repeat (10) @(negedge clk);
    check("abort strobes", 32'(got_q.size() - base), 32'd0);
    check("abort underruns", 32'(under_cnt - u0), 32'd0);
    check("abort spi_cs", 32'(spi_cs), 32'd1);
    run_xfer("after_abort", '{n:3'd1, mosi:{8'h00,8'h00,8'h00,8'h5A}, mode:'0, val:'0,
                              exp_miso:'0, exp_under:3'd0});

    // reset pulsed mid-transaction
    base = got_q.size();
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    partial_bits(8'hFF, 4);
    #1 reset_n = 1'b0;
    #1;
    check("midrst spi_cs", 32'(spi_cs), 32'd1);
    check("midrst miso_oe", 32'(spi_miso_oe), 32'd0);
    check("midrst miso", 32'(spi_miso), 32'd0);
    check("midrst rx_data", 32'(spi_rx_data), 32'd0);
    check("midrst strobe", 32'(spi_rx_strobe), 32'd0);
    spi_cs_n = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst strobes", 32'(got_q.size() - base), 32'd0);
    run_xfer("after_reset", '{n:3'd1, mosi:{8'h00,8'h00,8'h00,8'h81}, mode:'0, val:'0,
                              exp_miso:'0, exp_under:3'd0});

    // randomized transactions against the byte-level model
    for (int r = 0; r < 8; r++) begin
      rv = '0;
      rv.n = 3'($urandom_range(1, 4));
      for (int j = 0; j < 4; j++) begin
        rv.mosi[j] = 8'($urandom_range(0, 255));
        rv.mode[j] = 2'($urandom_range(0, 3));
        rv.val[j]  = 8'($urandom_range(0, 255));
      end
      run_xfer($sformatf("rand%0d", r), model(rv));
      repeat ($urandom_range(6, 12)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
